dbg_mem_bridge: RTL and testbench

- Host-side initiator for the core's debug memory ports: InstRAM and DataRAM port 2 (A2/WD2/WE2/RD2).
- Accepts a byte-serial command stream (from a UART receiver or similar) and parses framed read/write commands.
- Issues word accesses on the selected debug port and returns response bytes on a byte-serial stream.
- Sits outside RV32Core; used to load programs and inspect data memory.

---
 rtl/dbg_mem_bridge.sv | 202 ++++++++++++++++++++
 tb/tb_dbg_mem_bridge.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dbg_mem_bridge
// Brief    : Byte-serial command parser driving InstRAM/DataRAM debug port 2.
//            Optional mid-frame idle timeout: define DBG_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dbg_mem_bridge #(
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic [31:0] dram_a,
  output logic [31:0] dram_wd,
  output logic [3:0]  dram_we,
  input  logic [31:0] dram_rd,
  output logic [31:0] iram_a,
  output logic [31:0] iram_wd,
  output logic [3:0]  iram_we,
  input  logic [31:0] iram_rd,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_DATA    = 3'd2,
    S_WR      = 3'd3,
    S_RD_WAIT = 3'd4,
    S_RESP    = 3'd5
  } state_e;

  localparam logic [7:0] C_ACK = 8'h06;
  localparam logic [7:0] C_NAK = 8'h15;
  localparam int         C_LW  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_e            state_q, state_d;
  logic              is_wr_q, is_wr_d;
  logic              is_iram_q, is_iram_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rsp_q, rsp_d;
  logic [2:0]        rsp_len_q, rsp_len_d;
  logic [C_LW-1:0]   lat_q, lat_d;
  logic              cmd_hs, rsp_hs, valid_op, to_fire;

  assign cmd_hs   = cmd_valid && cmd_ready;
  assign rsp_hs   = rsp_valid && rsp_ready;
  assign valid_op = (cmd_data == 8'h10) || (cmd_data == 8'h11) ||
                    (cmd_data == 8'h20) || (cmd_data == 8'h21);

`ifdef DBG_TIMEOUT_EN
  localparam int C_TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [C_TW-1:0] to_q, to_d;

  // Fires on the idle cycle that would take the counter to zero.
  always_comb begin
    to_d    = to_q;
    to_fire = 1'b0;
    if (cmd_hs) begin
      to_d = C_TW'(TIMEOUT_CYCLES);
    end else if (state_q == S_ADDR || state_q == S_DATA) begin
      if (to_q <= C_TW'(1)) to_fire = 1'b1;
      else                  to_d    = to_q - C_TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) to_q <= '0;
    else     to_q <= to_d;
  end
`else
  // Timeout hardware absent; the parameter is kept for a uniform interface.
  assign to_fire = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d   = state_q;
    is_wr_d   = is_wr_q;
    is_iram_d = is_iram_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rsp_d     = rsp_q;
    rsp_len_d = rsp_len_q;
    lat_d     = lat_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_hs) begin
          if (valid_op) begin
            is_wr_d   = cmd_data[0];
            is_iram_d = cmd_data[5];
            cnt_d     = 2'd0;
            state_d   = S_ADDR;
          end else begin
            rsp_d     = {24'h0, C_NAK};
            rsp_len_d = 3'd1;
            state_d   = S_RESP;
          end
        end
      end
      S_ADDR: begin
        if (cmd_hs) begin
          addr_d = {cmd_data, addr_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            lat_d   = '0;
            state_d = is_wr_q ? S_DATA : S_RD_WAIT;
          end
        end else if (to_fire) begin
          rsp_d     = {24'h0, C_NAK};
          rsp_len_d = 3'd1;
          state_d   = S_RESP;
        end
      end
      S_DATA: begin
        if (cmd_hs) begin
          wdata_d = {cmd_data, wdata_q[31:8]};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_WR;
        end else if (to_fire) begin
          rsp_d     = {24'h0, C_NAK};
          rsp_len_d = 3'd1;
          state_d   = S_RESP;
        end
      end
      S_WR: begin
        rsp_d     = {24'h0, C_ACK};
        rsp_len_d = 3'd1;
        state_d   = S_RESP;
      end
      S_RD_WAIT: begin
        if (lat_q == C_LW'(READ_LATENCY - 1)) begin
          rsp_d     = is_iram_q ? iram_rd : dram_rd;
          rsp_len_d = 3'd4;
          state_d   = S_RESP;
        end else begin
          lat_d = lat_q + C_LW'(1);
        end
      end
      S_RESP: begin
        if (rsp_hs) begin
          rsp_d     = {8'h0, rsp_q[31:8]};
          rsp_len_d = rsp_len_q - 3'd1;
          if (rsp_len_q == 3'd1) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      is_wr_q   <= 1'b0;
      is_iram_q <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_q     <= '0;
      rsp_len_q <= '0;
      lat_q     <= '0;
    end else begin
      state_q   <= state_d;
      is_wr_q   <= is_wr_d;
      is_iram_q <= is_iram_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rsp_q     <= rsp_d;
      rsp_len_q <= rsp_len_d;
      lat_q     <= lat_d;
    end
  end

  // Outputs are gated by rst so an interrupted WR never reaches memory.
  logic mem_act, wr_act;
  assign mem_act   = !rst && (state_q == S_WR || state_q == S_RD_WAIT);
  assign wr_act    = !rst && (state_q == S_WR);

  assign cmd_ready = !rst && (state_q == S_IDLE || state_q == S_ADDR || state_q == S_DATA);
  assign rsp_valid = !rst && (state_q == S_RESP);
  assign rsp_data  = rst ? 8'h00 : rsp_q[7:0];
  assign busy      = !rst && (state_q != S_IDLE);

  assign dram_a  = (mem_act && !is_iram_q) ? addr_q  : 32'h0;
  assign dram_wd = (wr_act  && !is_iram_q) ? wdata_q : 32'h0;
  assign dram_we = (wr_act  && !is_iram_q) ? 4'hF    : 4'h0;
  assign iram_a  = (mem_act &&  is_iram_q) ? addr_q  : 32'h0;
  assign iram_wd = (wr_act  &&  is_iram_q) ? wdata_q : 32'h0;
  assign iram_we = (wr_act  &&  is_iram_q) ? 4'hF    : 4'h0;

endmodule
`default_nettype wire

// File: tb/tb_dbg_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_dbg_mem_bridge
// Brief    : Randomized self-checking bench for dbg_mem_bridge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dbg_mem_bridge;

  localparam int LAT = 1;
  localparam int TO  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_data = 8'h00;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_data;
  logic [31:0] dram_a, dram_wd, dram_rd, iram_a, iram_wd, iram_rd;
  logic [3:0]  dram_we, iram_we;
  logic        busy;

  always #5 clk = ~clk;

  dbg_mem_bridge #(.READ_LATENCY(LAT), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .dram_a(dram_a), .dram_wd(dram_wd), .dram_we(dram_we), .dram_rd(dram_rd),
    .iram_a(iram_a), .iram_wd(iram_wd), .iram_we(iram_we), .iram_rd(iram_rd),
    .busy(busy)
  );

  // Memories seen by the DUT (asynchronous read) and the reference copies.
  logic [31:0] dmem  [16];
  logic [31:0] imem  [16];
  logic [31:0] mdmem [16];
  logic [31:0] mimem [16];
  assign dram_rd = dmem[dram_a[3:0]];
  assign iram_rd = imem[iram_a[3:0]];

  int n_err = 0;
  int n_chk = 0;
  int n_dwe = 0;
  int n_iwe = 0;
  logic [31:0] last_da, last_dwd, last_ia, last_iwd;
  logic [3:0]  last_dwe, last_iwe;

  always @(negedge clk) begin
    #4;
    if (dram_we != 4'h0) begin
      n_dwe++; last_da = dram_a; last_dwd = dram_wd; last_dwe = dram_we;
      dmem[dram_a[3:0]] = dram_wd;
    end
    if (iram_we != 4'h0) begin
      n_iwe++; last_ia = iram_a; last_iwd = iram_wd; last_iwe = iram_we;
      imem[iram_a[3:0]] = iram_wd;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    cmd_valid = 1'b1;
    cmd_data  = b;
    while (!cmd_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = 8'($urandom);
  endtask

  task automatic get_bytes(input int n, output logic [31:0] w);
    logic [7:0] held;
    bit have_held, got;
    int k;
    w = 32'h0;
    for (int i = 0; i < n; i++) begin
      have_held = 1'b0;
      got = 1'b0;
      k = 0;
      while (!got && k < 300) begin
        rsp_ready = ($urandom_range(0, 2) != 0);
        #1;
        if (rsp_valid) begin
          if (have_held) chk("rsp_hold", 32'(rsp_data), 32'(held));
          if (rsp_ready) begin
            w[8*i +: 8] = rsp_data;
            got = 1'b1;
          end else begin
            held = rsp_data;
            have_held = 1'b1;
          end
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        k++;
      end
      if (!got) begin
        chk("rsp_wait", 32'(got), 32'd1);
        return;
      end
    end
  endtask

  task automatic do_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
    int d0, i0;
    logic [31:0] got;
    bit ok, wr, im;
    ok = (op == 8'h10) || (op == 8'h11) || (op == 8'h20) || (op == 8'h21);
    wr = ok && op[0];
    im = op[5];
    d0 = n_dwe;
    i0 = n_iwe;
    send_byte(op); gap();
    if (ok) for (int i = 0; i < 4; i++) begin send_byte(a[8*i +: 8]); gap(); end
    if (wr) for (int i = 0; i < 4; i++) begin send_byte(d[8*i +: 8]); gap(); end
    if (!ok || wr) begin
      get_bytes(1, got);
      chk("ack_byte", got, ok ? 32'h06 : 32'h15);
    end else begin
      get_bytes(4, got);
      chk("read_data", got, im ? mimem[a[3:0]] : mdmem[a[3:0]]);
    end
    chk("dram_we_count", 32'(n_dwe - d0), (wr && !im) ? 32'd1 : 32'd0);
    chk("iram_we_count", 32'(n_iwe - i0), (wr &&  im) ? 32'd1 : 32'd0);
    if (wr && !im) begin
      chk("dram_a", last_da, a); chk("dram_wd", last_dwd, d); chk("dram_we", 32'(last_dwe), 32'hF);
      mdmem[a[3:0]] = d;
    end
    if (wr && im) begin
      chk("iram_a", last_ia, a); chk("iram_wd", last_iwd, d); chk("iram_we", 32'(last_iwe), 32'hF);
      mimem[a[3:0]] = d;
    end
    chk("idle_ready", {31'h0, cmd_ready}, 32'd1);
    chk("idle_busy", {31'h0, busy}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    logic [7:0]  b0;
    int i0, bad;
    logic [7:0] ops [5];

    for (int i = 0; i < 16; i++) begin
      dmem[i] = $urandom; mdmem[i] = dmem[i];
      imem[i] = $urandom; mimem[i] = imem[i];
    end
    imem[4] = 32'h00C58533; mimem[4] = 32'h00C58533;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_mem_out", dram_a | dram_wd | iram_a | iram_wd | 32'(dram_we) | 32'(iram_we), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'h0, cmd_ready}, 32'd1);
    @(negedge clk);

    // Directed frames
    do_frame(8'h11, 32'h12345678, 32'hDEADBEEF);
    do_frame(8'h20, 32'h00000004, 32'h0);
    chk("iram_word4", mimem[4], 32'h00C58533);
    do_frame(8'h7F, 32'h0, 32'h0);
    do_frame(8'h10, 32'h12345678, 32'h0);

    // Backpressure during a read response
    send_byte(8'h20);
    for (int i = 0; i < 4; i++) send_byte(8'(i == 0 ? 4 : 0));
    i0 = 0;
    while (!rsp_valid && i0 < 20) begin @(negedge clk); i0++; end
    b0 = rsp_data;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_data != b0 || !rsp_valid || cmd_ready) bad++;
    end
    chk("stall_stable", 32'(bad), 32'd0);
    w = 32'h0;
    for (int i = 0; i < 4; i++) begin
      w[8*i +: 8] = rsp_data;
      if (cmd_ready) bad++;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      @(negedge clk);
    end
    chk("stall_data", w, 32'h00C58533);
    chk("stall_cmd_ready", 32'(bad), 32'd0);
    chk("stall_done_idle", {31'h0, busy}, 32'd0);

    // Reset in the middle of an InstRAM write frame
    i0 = n_iwe;
    send_byte(8'h21);
    for (int i = 0; i < 3; i++) send_byte(8'h55);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", {31'h0, busy}, 32'd0);
    chk("midrst_ready", {31'h0, cmd_ready}, 32'd1);
    @(negedge clk);
    chk("midrst_no_we", 32'(n_iwe - i0), 32'd0);
    do_frame(8'h21, 32'h00000009, 32'hCAFEF00D);
    do_frame(8'h20, 32'h00000009, 32'h0);

`ifdef DBG_TIMEOUT_EN
    i0 = n_dwe;
    send_byte(8'h10);
    send_byte(8'h00);
    repeat (15) @(negedge clk);
    chk("to_not_yet", {31'h0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("to_fired", {31'h0, rsp_valid}, 32'd1);
    get_bytes(1, w);
    chk("to_nak", w, 32'h15);
    chk("to_no_access", 32'(n_dwe - i0), 32'd0);
    send_byte(8'h10);
    send_byte(8'h00);
    repeat (15) @(negedge clk);
    for (int i = 0; i < 3; i++) send_byte(8'h00);
    get_bytes(4, w);
    chk("to_late_ok", w, mdmem[0]);
`endif

    // Randomized frames against the reference model
    ops[0] = 8'h10; ops[1] = 8'h11; ops[2] = 8'h20; ops[3] = 8'h21; ops[4] = 8'h00;
    for (int n = 0; n < 40; n++) begin
      int s;
      logic [7:0] op;
      s  = $urandom_range(0, 4);
      op = (s == 4) ? 8'($urandom) : ops[s];
      do_frame(op, $urandom, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
